// File: rtl/cbus_arbiter_if.sv
// Shared cbus request/response types and the arbiter's bus interface.
// slave = arbiter side, master = requester/bus environment side.
package cbus_pkg;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic [7:0]  len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

endpackage

interface cbus_arbiter_if #(
  parameter int NUM_INPUTS = 2
);
  import cbus_pkg::*;

  localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  // Handshake: a requester raises valid with a stable request and holds it until it
  // sees ready && last; every cycle with ready high is one accepted beat of the burst.
  cbus_req_t        ireqs  [NUM_INPUTS];
  cbus_resp_t       iresps [NUM_INPUTS];
  cbus_req_t        oreq;
  cbus_resp_t       oresp;
  logic             busy;
  logic [IDX_W-1:0] grant_idx;
  arb_state_t       state;

  modport slave (
    input  ireqs, oresp,
    output iresps, oreq, busy, grant_idx, state
  );

  modport master (
    output ireqs, oresp,
    input  iresps, oreq, busy, grant_idx, state
  );

endinterface

// File: rtl/cbus_arbiter.sv
// Burst-granular arbiter sharing one cbus among NUM_INPUTS requesters.
// Define CBUS_ARB_ROUND_ROBIN_EN for rotating priority; otherwise lowest index wins.
module cbus_arbiter
  import cbus_pkg::*;
#(
  parameter int NUM_INPUTS = 2
) (
  input  logic          clk,
  input  logic          reset,
  cbus_arbiter_if.slave bus
);

  localparam int               IDX_W    = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INPUTS - 1);
  localparam logic [IDX_W:0]   N_W      = (IDX_W + 1)'(NUM_INPUTS);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_found;
  logic [IDX_W:0]   cand;
  logic             burst_done;

  assign burst_done = bus.oresp.ready & bus.oresp.last;

  // First valid requester at or after the pointer, wrapping around.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = ptr_q;
    cand      = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      cand = {1'b0, ptr_q} + (IDX_W + 1)'(i);
      if (cand >= N_W) begin
        cand = cand - N_W;
      end
      if (!sel_found && bus.ireqs[cand[IDX_W-1:0]].valid) begin
        sel_found = 1'b1;
        sel_idx   = cand[IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    case (state_q)
      ARB_IDLE: begin
        if (sel_found) begin
          grant_d = sel_idx;
          state_d = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (burst_done) begin
          state_d = ARB_IDLE;
`ifdef CBUS_ARB_ROUND_ROBIN_EN
          ptr_d   = (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;
`else
          ptr_d   = '0;
`endif
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Only the granted requester is connected; everything else reads as zero.
  always_comb begin
    bus.oreq = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      bus.iresps[i] = '0;
    end
    if (state_q == ARB_BUSY) begin
      bus.oreq            = bus.ireqs[grant_q];
      bus.iresps[grant_q] = bus.oresp;
    end
  end

  assign bus.busy      = (state_q == ARB_BUSY);
  assign bus.grant_idx = grant_q;
  assign bus.state     = state_q;

endmodule

// File: doc/cbus_arbiter.md
CBUS_ARBITER -- requirements
Module: cbus_arbiter

Interface
REQ-001 Parameter NUM_INPUTS, default 2, number of cbus requesters; index 0 is the icache port and index 1 the dcache port when used in the cache subsystem.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 ireqs  input  cbus_req_t[NUM_INPUTS]  requester bus requests (valid, is_write, size, addr, strobe, data, len).
REQ-005 iresps  output  cbus_resp_t[NUM_INPUTS]  per-requester responses (ready, last, data).
REQ-006 oreq  output  cbus_req_t  request driven to the shared cbus.
REQ-007 oresp  input  cbus_resp_t  response from the shared cbus.
REQ-008 busy  output  1  high while a grant is held (state BUSY).
REQ-009 grant_idx  output  $clog2(NUM_INPUTS)  index of the current or most recent granted requester.

Function
REQ-010 State machine SHALL have two states, IDLE and BUSY.
REQ-011 In IDLE, oreq SHALL be all-zero and every iresps[i] SHALL be all-zero.
REQ-012 In IDLE, if any ireqs[i].valid is high, the block SHALL select one requester per REQ-020/021, register it in grant_idx and enter BUSY at the next edge.
REQ-013 In IDLE with no valid request, state, grant_idx and priority pointer SHALL hold.
REQ-014 In BUSY, oreq SHALL equal ireqs[grant_idx] combinationally.
REQ-015 In BUSY, iresps[grant_idx] SHALL equal oresp, and every other iresps[i] SHALL be all-zero.
REQ-016 Request-to-oreq.valid latency SHALL be exactly 1 cycle; a burst of N beats is held for N ready beats plus that cycle.
REQ-017 BUSY -> IDLE SHALL occur on the edge where oresp.ready and oresp.last are both high; that burst's last beat is still forwarded to the granted requester in that cycle.
REQ-018 No new grant is made in the cycle of BUSY -> IDLE; the earliest next grant is 1 cycle later, giving a mandatory 1-cycle IDLE gap between bursts.
REQ-019 If ireqs[grant_idx].valid drops in BUSY, the block SHALL stay BUSY and forward the invalid request unchanged until oresp.last; requesters are required to hold valid until last.
REQ-020 Selection SHALL use a priority pointer (reset 0): the first valid index at or after the pointer, wrapping modulo NUM_INPUTS.
REQ-021 On BUSY -> IDLE the pointer SHALL become (grant_idx + 1) mod NUM_INPUTS.
REQ-022 Non-granted requesters SHALL see ready = 0 and last = 0 until they are granted; their requests are never dropped.
REQ-023 oresp beats arriving in IDLE SHALL be ignored and not forwarded.
REQ-024 busy SHALL be 1 exactly when the state is BUSY.

Reset
REQ-025 While reset is high at an edge: state to IDLE, grant_idx to 0 and pointer to 0; oreq, iresps and busy are 0 from the following cycle.
REQ-026 Reset during BUSY SHALL abandon the burst with no completion signalled to the requester.

Configuration
REQ-027 Macro CBUS_ARB_ROUND_ROBIN_EN defined: selection per REQ-020/021.
REQ-028 Macro undefined: fixed priority, lowest valid index wins, and the pointer is held at 0.

Verification
REQ-029 Only ireqs[0] valid, len=0 read, and oresp ready+last in the second BUSY cycle -> oreq.valid rises 1 cycle after the request; iresps[0] sees ready=1, last=1 with the data; IDLE follows; grant_idx=0.
REQ-030 Both requests valid at once from reset, each a 4-beat burst, with CBUS_ARB_ROUND_ROBIN_EN defined -> order 0, 1, 0, 1 with a 1-cycle IDLE gap between bursts; iresps[1] is zero during the 0 bursts.
REQ-031 Same as REQ-030 with CBUS_ARB_ROUND_ROBIN_EN undefined -> requester 0 is granted every time and requester 1 only once ireqs[0].valid is low at selection.
REQ-032 ireqs[1] write burst, len=3, and ireqs[0] asserted mid-burst -> oreq stays equal to ireqs[1] until the 4th ready+last; grant goes to 0 two cycles later.
REQ-033 reset pulsed for 1 cycle during beat 2 of a BUSY burst -> next cycle busy=0, oreq=0, grant_idx=0, and a pending request is regranted 1 cycle after reset is low.
REQ-034 oresp.ready=1 with last=1 injected while IDLE -> no iresps activity and the state is unchanged.
